// File: rtl/uart8_rx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart8_rx_ctrl_pkg
//   Shared definitions for the 8-bit UART receive controller:
//     - state_t       : controller state encodings (2-bit)
//                       DISABLED / ARMING / ACTIVE / LOCKOUT
//     - ERR_COUNT_MAX : saturation value of the error counter
//     - sat_inc8      : saturating 8-bit increment helper
// ---------------------------------------------------------------------------
package uart8_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == ERR_COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart8_rx_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Small byte FIFO used by the UART receive controller.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push, wdata : write request and byte; accepted when not full, or when
//                   full and a pop is accepted in the same tick
//     pop         : read request; ignored when empty
//     rdata       : head entry, 0 when empty
//     full, empty : occupancy flags
//     level       : current occupancy (0..DEPTH)
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a byte when the head leaves in the same tick.
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? 8'h00 : mem[rd_ptr];
    assign level = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart8_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart8_rx_ctrl
//   Controller/sequencer for the 8-bit UART receiver. Arms the receiver after
//   enable, captures completed bytes into a FIFO with a valid/ready output,
//   counts receiver errors and locks the receiver out after MAX_ERRS
//   consecutive errors.
//
//   Handshake: a byte leaves the FIFO on every clk edge where
//   m_valid && m_ready; m_valid only depends on FIFO occupancy, never on
//   m_ready, and m_data is stable while m_valid is high and no pop happens.
//
//   Ports:
//     clk, rst_n        : 16x oversample clock, async active-low reset
//     enable            : controller enable, low forces DISABLED
//     clear_stat        : one-tick pulse clearing overrun/err_count/locked_out
//     rx_busy           : receiver busy (informational, not used)
//     rx_done, rx_data  : receiver byte-complete level and parallel data
//     rx_err            : receiver error level
//     rx_en             : receiver enable (registered)
//     m_data, m_valid,
//     m_ready           : FIFO head output stream
//     fifo_level        : FIFO occupancy
//     overrun           : sticky, byte dropped on a full FIFO
//     err_count         : saturating count of rx_err rising edges
//     locked_out        : sticky, LOCKOUT entered at least once
//     rx_timeout        : idle timeout flag
//     dbg_state         : current controller state (debug)
//
//   Optional feature: define UART_RX_CTRL_TIMEOUT_EN to enable the idle
//   timeout; otherwise rx_timeout is tied to 0.
// ---------------------------------------------------------------------------
module uart8_rx_ctrl
    import uart8_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int ARM_TICKS     = 32,
    parameter int MAX_ERRS      = 3,
    parameter int LOCKOUT_TICKS = 512,
    parameter int TIMEOUT_TICKS = 160
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          clear_stat,
    input  logic                          rx_busy,
    input  logic                          rx_done,
    input  logic                          rx_err,
    input  logic [7:0]                    rx_data,
    output logic                          rx_en,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic [7:0]                    err_count,
    output logic                          locked_out,
    output logic                          rx_timeout,
    output logic [1:0]                    dbg_state
);

    // One counter width fits every tick interval the controller times.
    localparam int MAX_AL   = (ARM_TICKS > LOCKOUT_TICKS) ? ARM_TICKS : LOCKOUT_TICKS;
    localparam int MAX_TICK = (MAX_AL > TIMEOUT_TICKS) ? MAX_AL : TIMEOUT_TICKS;
    localparam int CNT_W    = $clog2(MAX_TICK + 1);

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [3:0]       consec_errs;
    logic [3:0]       consec_next;
    logic             done_prev;
    logic             err_prev;

    logic             done_rise;
    logic             err_rise;
    logic             capture;
    logic             err_evt;
    logic             pop;
    logic             push_acc;
    logic             drop;
    logic             lock_trig;
    logic             fifo_full;
    logic             fifo_empty;

    // The controller works purely from done/err edges; busy is not needed.
    logic             unused_rx_busy;
    assign unused_rx_busy = rx_busy;

    assign done_rise = rx_done && !done_prev;
    assign err_rise  = rx_err && !err_prev;
    assign capture   = done_rise && (state == ST_ACTIVE);
    assign err_evt   = err_rise && (state != ST_DISABLED);
    assign pop       = m_valid && m_ready;
    assign push_acc  = capture && (!fifo_full || pop);
    assign drop      = capture && fifo_full && !pop;
    assign lock_trig = enable && (state == ST_ACTIVE) && (consec_next >= 4'(MAX_ERRS));
    assign dbg_state = state;
    assign m_valid   = !fifo_empty;

    // An error edge wins over a good byte in the same tick.
    always_comb begin
        consec_next = consec_errs;
        if (err_evt) begin
            consec_next = (consec_errs == 4'hF) ? 4'hF : consec_errs + 4'd1;
        end else if (capture) begin
            consec_next = 4'd0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .pop   (pop),
        .wdata (rx_data),
        .rdata (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_prev <= 1'b0;
            err_prev  <= 1'b0;
        end else begin
            done_prev <= rx_done;
            err_prev  <= rx_err;
        end
    end

    // Controller FSM. Later assignments to consec_errs override the
    // per-tick update so entry to ARMING always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_DISABLED;
            tick_cnt    <= '0;
            rx_en       <= 1'b0;
            consec_errs <= 4'd0;
        end else begin
            consec_errs <= consec_next;
            if (!enable) begin
                state    <= ST_DISABLED;
                rx_en    <= 1'b0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    ST_DISABLED: begin
                        state       <= ST_ARMING;
                        rx_en       <= 1'b0;
                        tick_cnt    <= '0;
                        consec_errs <= 4'd0;
                    end
                    ST_ARMING: begin
                        if (tick_cnt == CNT_W'(ARM_TICKS - 1)) begin
                            state    <= ST_ACTIVE;
                            rx_en    <= 1'b1;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    ST_ACTIVE: begin
                        if (lock_trig) begin
                            state    <= ST_LOCKOUT;
                            rx_en    <= 1'b0;
                            tick_cnt <= '0;
                        end
                    end
                    ST_LOCKOUT: begin
                        if (tick_cnt == CNT_W'(LOCKOUT_TICKS - 1)) begin
                            state       <= ST_ARMING;
                            tick_cnt    <= '0;
                            consec_errs <= 4'd0;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_DISABLED;
                        rx_en    <= 1'b0;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Status flags: a set in the same tick as clear_stat wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun    <= 1'b0;
            err_count  <= 8'd0;
            locked_out <= 1'b0;
        end else begin
            if (clear_stat) begin
                overrun    <= drop;
                locked_out <= lock_trig;
                err_count  <= err_evt ? 8'd1 : 8'd0;
            end else begin
                if (drop) begin
                    overrun <= 1'b1;
                end
                if (lock_trig) begin
                    locked_out <= 1'b1;
                end
                if (err_evt) begin
                    err_count <= sat_inc8(err_count);
                end
            end
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt;

    // idle_cnt saturates at TIMEOUT_TICKS; the flag sets on the tick the
    // count completes and stays until the next push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            if (push_acc || fifo_empty) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CNT_W'(TIMEOUT_TICKS)) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
            if (push_acc || pop) begin
                rx_timeout <= 1'b0;
            end else if (!fifo_empty && (idle_cnt == CNT_W'(TIMEOUT_TICKS - 1))) begin
                rx_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_push_acc;
    assign unused_push_acc = push_acc;
    assign rx_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_uart8_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart8_rx_ctrl
//   Directed scenarios plus a randomized phase checked against a behavioural
//   model (byte queue, error counters, lockout countdown).
// ---------------------------------------------------------------------------
module tb_uart8_rx_ctrl;
    import uart8_rx_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int ARM   = 32;
    localparam int LOCK  = 512;
    localparam int MAXE  = 3;

    // clock / reset
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic       enable, clear_stat, rx_busy, rx_done, rx_err, m_ready;
    logic [7:0] rx_data;
    logic       rx_en, m_valid, overrun, locked_out, rx_timeout;
    logic [7:0] m_data, err_count;
    logic [2:0] fifo_level;
    logic [1:0] dbg_state;

    uart8_rx_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clear_stat (clear_stat),
        .rx_busy    (rx_busy),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .err_count  (err_count),
        .locked_out (locked_out),
        .rx_timeout (rx_timeout),
        .dbg_state  (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_busy = 1'b1;
        rx_done = 1'b1;
        repeat (16) step();
        rx_done = 1'b0;
        rx_busy = 1'b0;
        step();
    endtask

    // scoreboard / reference model
    logic [7:0] exp_q[$];
    int m_errs, m_consec, m_wake;
    bit m_active, m_locked, m_ovr, m_dprev, m_eprev;

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit d_edge, e_edge, do_pop, cap;
        d_edge = (rx_done === 1'b1) && !m_dprev;
        e_edge = (rx_err === 1'b1) && !m_eprev;
        do_pop = (m_ready === 1'b1) && (exp_q.size() > 0);
        cap    = d_edge && m_active;
        if (do_pop) exp_q.delete(0);
        if (cap) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rx_data);
            else m_ovr = 1'b1;
        end
        if (e_edge) begin
            if (m_errs < 255) m_errs++;
            if (m_consec < 15) m_consec++;
        end else if (cap) begin
            m_consec = 0;
        end
        if (!m_active) begin
            m_wake--;
            if (m_wake == ARM) m_consec = 0;
            if (m_wake == 0) m_active = 1'b1;
        end else if (m_consec >= MAXE) begin
            m_active = 1'b0;
            m_locked = 1'b1;
            m_wake   = LOCK + ARM;
        end
        m_dprev = rx_done;
        m_eprev = rx_err;
    endtask

    task automatic check_outputs_zero(input string pfx);
        chk({pfx, "_rx_en"},      rx_en, 0);
        chk({pfx, "_m_valid"},    m_valid, 0);
        chk({pfx, "_m_data"},     m_data, 0);
        chk({pfx, "_level"},      fifo_level, 0);
        chk({pfx, "_overrun"},    overrun, 0);
        chk({pfx, "_err_count"},  err_count, 0);
        chk({pfx, "_locked_out"}, locked_out, 0);
        chk({pfx, "_rx_timeout"}, rx_timeout, 0);
    endtask

    initial begin
        int k;
        int ready_pct, err_pct, done_pct;
        rst_n = 1'b0; enable = 1'b0; clear_stat = 1'b0; rx_busy = 1'b0;
        rx_done = 1'b0; rx_err = 1'b0; m_ready = 1'b0; rx_data = 8'h00;

        // reset state
        repeat (2) step();
        check_outputs_zero("reset");
        chk("reset_state", dbg_state, ST_DISABLED);
        rst_n = 1'b1;
        step();

        // arming: rx_en low 32 ticks, high on the 33rd
        enable = 1'b1;
        for (int i = 1; i <= ARM; i++) begin
            step();
            chk($sformatf("arm_low_%0d", i), rx_en, 0);
        end
        step();
        chk("arm_high", rx_en, 1);

        // single byte appears the tick after the done edge
        rx_data = 8'hA5; rx_done = 1'b1;
        step();
        chk("t1_valid", m_valid, 1);
        chk("t1_data",  m_data, 8'hA5);
        chk("t1_level", fifo_level, 1);
        repeat (15) step();
        rx_done = 1'b0;
        step();
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("t1_drained", m_valid, 0);

        // overflow: five bytes into four entries
        for (int b = 1; b <= 5; b++) send_byte(8'(b));
        chk("t2_level",   fifo_level, 4);
        chk("t2_overrun", overrun, 1);
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("t2_order_%0d", b), m_data, b);
            m_ready = 1'b1; step(); m_ready = 1'b0;
        end
        chk("t2_empty", m_valid, 0);
        clear_stat = 1'b1; step(); clear_stat = 1'b0;
        chk("t2_clear", overrun, 0);

        // full FIFO with push and pop in the same tick
        for (int b = 0; b < 4; b++) send_byte(8'(8'h10 + b));
        rx_data = 8'h14; rx_done = 1'b1; m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t3_level",   fifo_level, 4);
        chk("t3_overrun", overrun, 0);
        chk("t3_head",    m_data, 8'h11);
        repeat (15) step();
        rx_done = 1'b0;
        step();
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("t3_order_%0d", b), m_data, 8'h10 + b);
            m_ready = 1'b1; step(); m_ready = 1'b0;
        end

        // randomized phase against the model
        exp_q.delete();
        m_errs = 0; m_consec = 0; m_wake = 0;
        m_active = 1'b1; m_locked = 1'b0; m_ovr = 1'b0;
        m_dprev = 1'b0; m_eprev = 1'b0;
        ready_pct = 50; err_pct = 2; done_pct = 35;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (cyc % 200 == 0) begin
                ready_pct = $urandom_range(0, 100);
                if ((cyc / 200) % 3 == 2) begin
                    err_pct = 25; done_pct = 5;
                end else begin
                    err_pct = 2; done_pct = 35;
                end
            end
            rx_done = ($urandom_range(0, 99) < done_pct);
            rx_err  = ($urandom_range(0, 99) < err_pct);
            rx_data = 8'($urandom);
            m_ready = ($urandom_range(0, 99) < ready_pct);
            model_step();
            step();
            chk("rnd_valid",   m_valid, exp_q.size() != 0);
            chk("rnd_data",    m_data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
            chk("rnd_level",   fifo_level, exp_q.size());
            chk("rnd_overrun", overrun, m_ovr);
            chk("rnd_errs",    err_count, m_errs);
            chk("rnd_locked",  locked_out, m_locked);
            chk("rnd_rx_en",   rx_en, m_active);
        end
        rx_done = 1'b0; rx_err = 1'b0; m_ready = 1'b0;

        // fresh start for lockout
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("rst2_errs", err_count, 0);
        repeat (ARM + 1) step();
        chk("rst2_active", rx_en, 1);

        // three consecutive error edges -> lockout, then 512 + 32 ticks low
        for (int e = 0; e < MAXE; e++) begin
            rx_err = 1'b1; step();
            if (e < MAXE - 1) begin
                rx_err = 1'b0; step();
            end
        end
        chk("t4_errs",   err_count, 3);
        chk("t4_locked", locked_out, 1);
        chk("t4_rx_en",  rx_en, 0);
        chk("t4_state",  dbg_state, ST_LOCKOUT);
        rx_err = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (rx_en !== 1'b1 && k < 2000);
        chk("t4_low_ticks", k, LOCK + ARM);

        // clear_stat coincident with an error edge: set wins
        clear_stat = 1'b1; rx_err = 1'b1; step();
        clear_stat = 1'b0; rx_err = 1'b0;
        chk("clr_err_count", err_count, 1);
        chk("clr_locked",    locked_out, 0);

        // clear_stat coincident with an overrun: set wins
        for (int b = 0; b < 4; b++) send_byte(8'(8'h20 + b));
        rx_data = 8'h24; rx_done = 1'b1; clear_stat = 1'b1;
        step();
        clear_stat = 1'b0;
        chk("clr_overrun", overrun, 1);
        chk("clr_level",   fifo_level, 4);
        repeat (15) step();
        rx_done = 1'b0;
        m_ready = 1'b1; repeat (4) step(); m_ready = 1'b0;
        chk("clr_drained", m_valid, 0);

        // idle timeout
        send_byte(8'h5A);
        repeat (200) step();
`ifdef UART_RX_CTRL_TIMEOUT_EN
        chk("t6_timeout_set", rx_timeout, 1);
`else
        chk("t6_timeout_tied", rx_timeout, 0);
`endif
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("t6_timeout_clr", rx_timeout, 0);

        // disable mid-byte keeps the FIFO, async reset clears everything
        rx_data = 8'h77; rx_done = 1'b1; rx_busy = 1'b1;
        step();
        enable = 1'b0;
        step();
        chk("t5_rx_en",  rx_en, 0);
        chk("t5_kept",   m_valid, 1);
        chk("t5_data",   m_data, 8'h77);
        chk("t5_state",  dbg_state, ST_DISABLED);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_async");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
